// File: rtl/btle_rx_pdu_reporter.sv
// Reads a decoded PDU out of the phy rx octet RAM and streams it as an HCI event frame.
// Optional macro BTLE_RX_REPORT_CRC_FILTER_EN: suppress (and count) events with a bad CRC.
module btle_rx_pdu_reporter #(
    parameter int         PDU_ADDR_BIT_WIDTH = 6,
    parameter logic [7:0] HCI_PKT_INDICATOR  = 8'h04,
    parameter logic [7:0] HCI_EVENT_CODE     = 8'h3E
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rpt_enable,
    input  logic                          rx_decode_end,
    input  logic                          rx_crc_ok,
    input  logic [2:0]                    rx_best_phase,
    input  logic [6:0]                    rx_payload_length,
    output logic [PDU_ADDR_BIT_WIDTH-1:0] rx_pdu_octet_mem_addr,
    input  logic [7:0]                    rx_pdu_octet_mem_data,
    output logic [7:0]                    tx_byte,
    output logic                          tx_byte_valid,
    input  logic                          tx_byte_ready,
    output logic                          busy,
    output logic [7:0]                    drop_cnt
);

    localparam int              AW     = PDU_ADDR_BIT_WIDTH;
    localparam logic [8:0]      MAX_N9 = 9'(1 << AW);
    localparam logic [AW:0]     MAX_N  = MAX_N9[AW:0];

    typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT, SEND} state_t;

    state_t      state, state_nxt;
    logic [1:0]  hdr_idx;
    logic [AW:0] oct_idx;
    logic [AW:0] n_q;
    logic        crc_q;
    logic [2:0]  phase_q;
    logic [7:0]  hold_q;
    logic        send_first;
    logic        event_ok;
    logic        start;
    logic        drop;
    logic        accept;
    logic        last_oct;
    logic [7:0]  len_byte;

    function automatic logic [AW:0] clamp_n(input logic [6:0] plen);
        logic [8:0] raw;
        raw = {2'b00, plen} + 9'd2;
        if (raw > MAX_N9)
            clamp_n = MAX_N;
        else
            clamp_n = raw[AW:0];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef BTLE_RX_REPORT_CRC_FILTER_EN
    assign event_ok = rx_crc_ok;
`else
    assign event_ok = 1'b1;
`endif

    assign busy          = (state != IDLE);
    assign tx_byte_valid = (state == HDR) || (state == SEND);
    assign accept        = tx_byte_valid && tx_byte_ready;
    assign last_oct      = (oct_idx == n_q - 1'b1);
    assign len_byte      = 8'(n_q) + 8'd1;
    assign start         = (state == IDLE) && rpt_enable && rx_decode_end && event_ok;
    // Events arriving while a frame is in flight (including its final accept) are lost.
    assign drop          = rx_decode_end &&
                           (busy || ((state == IDLE) && rpt_enable && !event_ok));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = HDR;
            HDR:   if (accept && hdr_idx == 2'd3) state_nxt = FETCH;
            FETCH: state_nxt = WAIT;
            WAIT:  state_nxt = SEND;
            SEND:  if (accept) state_nxt = last_oct ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM data is live on the first SEND cycle; afterwards the captured copy keeps it stable.
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            HDR: begin
                case (hdr_idx)
                    2'd0:    tx_byte = HCI_PKT_INDICATOR;
                    2'd1:    tx_byte = HCI_EVENT_CODE;
                    2'd2:    tx_byte = len_byte;
                    default: tx_byte = {crc_q, phase_q, 4'b0000};
                endcase
            end
            SEND:    tx_byte = send_first ? rx_pdu_octet_mem_data : hold_q;
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            hdr_idx               <= 2'd0;
            oct_idx               <= '0;
            rx_pdu_octet_mem_addr <= '0;
            send_first            <= 1'b0;
            drop_cnt              <= 8'h00;
        end else begin
            state <= state_nxt;
            if (drop)
                drop_cnt <= sat_inc(drop_cnt);
            case (state)
                IDLE: begin
                    if (start) begin
                        hdr_idx <= 2'd0;
                        oct_idx <= '0;
                    end
                end
                HDR:   if (accept) hdr_idx <= hdr_idx + 1'b1;
                FETCH: rx_pdu_octet_mem_addr <= oct_idx[AW-1:0];
                WAIT:  send_first <= 1'b1;
                SEND: begin
                    send_first <= 1'b0;
                    if (accept)
                        oct_idx <= oct_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            crc_q   <= rx_crc_ok;
            phase_q <= rx_best_phase;
            n_q     <= clamp_n(rx_payload_length);
        end
        if (state == SEND && send_first)
            hold_q <= rx_pdu_octet_mem_data;
    end

endmodule
